// File: rtl/clk_domain_pkg.sv
// Shared types and constants for the clock-domain reset sequencer.
// The state codes are visible on SEQ_STATE, so their values are fixed.
package clk_domain_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    WAIT_STABLE  = 3'd0,
    HOLD         = 3'd1,
    RELEASE_CORE = 3'd2,
    RUN          = 3'd3,
    FAULT        = 3'd4
  } seq_state_e;

  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_HOLD_CYCLES        = 16;
  localparam int DEF_STAGGER_CYCLES     = 8;
  localparam int DEF_LOCK_FILTER_CYCLES = 4;

  localparam int CNT_W  = 16;
  localparam int FILT_W = 8;
  localparam int LOSS_W = 8;

  // Saturating increment for the lock-loss event counter
  function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
    if (v == {LOSS_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + LOSS_W'(1);
    end
  endfunction

endpackage

// File: rtl/clock_domain_reset_sequencer_if.sv
// Status/reset bundle between the clock generator side and the sequencer.
interface clock_domain_reset_sequencer_if;

  logic                               CLOCKS_STABLE_H;
  logic                               MMCM_LOCKED_H;
  logic                               SEQ_RESTART_H;
  logic                               CORE_RESET_H;
  logic                               FABRIC_RESET_H;
  logic                               RELOCK_REQUEST_H;
  logic [clk_domain_pkg::STATE_W-1:0] SEQ_STATE;
  logic [clk_domain_pkg::LOSS_W-1:0]  LOCK_LOSS_COUNT;

  modport slave (
    input  CLOCKS_STABLE_H, MMCM_LOCKED_H, SEQ_RESTART_H,
    output CORE_RESET_H, FABRIC_RESET_H, RELOCK_REQUEST_H, SEQ_STATE, LOCK_LOSS_COUNT
  );

  modport master (
    output CLOCKS_STABLE_H, MMCM_LOCKED_H, SEQ_RESTART_H,
    input  CORE_RESET_H, FABRIC_RESET_H, RELOCK_REQUEST_H, SEQ_STATE, LOCK_LOSS_COUNT
  );

endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level; STAGES must be >= 2.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift chain, cleared to 0 on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/clock_domain_reset_sequencer.sv
// Sequences core/fabric reset release after clock qualification and
// watches MMCM lock, forcing a relock cycle when lock is lost.
module clock_domain_reset_sequencer
  import clk_domain_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES        = DEF_HOLD_CYCLES,
  parameter int STAGGER_CYCLES     = DEF_STAGGER_CYCLES,
  parameter int LOCK_FILTER_CYCLES = DEF_LOCK_FILTER_CYCLES
) (
  input  logic                           CLK_80MHz,
  input  logic                           RESET_H,
  clock_domain_reset_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STAG_LAST  = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_LAST  = FILT_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_LIMIT = FILT_W'(LOCK_FILTER_CYCLES);

  seq_state_e          state_r, next_s;
  logic [CNT_W-1:0]    cnt_r, cnt_next_s;
  logic [FILT_W-1:0]   lock_cnt_r, lock_cnt_next_s;
  logic [LOSS_W-1:0]   loss_cnt_r;
  logic                core_reset_r, fabric_reset_r, relock_r;
  logic                stable_s, lock_s, lock_loss_s;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_stable (
    .clk (CLK_80MHz),
    .rst (RESET_H),
    .d   (bus.CLOCKS_STABLE_H),
    .q   (stable_s)
  );

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk (CLK_80MHz),
    .rst (RESET_H),
    .d   (bus.MMCM_LOCKED_H),
    .q   (lock_s)
  );

  // Lock filter: loss fires on the edge that would see the Nth consecutive low
  always_comb begin
    lock_cnt_next_s = lock_cnt_r;
    if (lock_s) begin
      lock_cnt_next_s = '0;
    end else if (lock_cnt_r != FILT_LIMIT) begin
      lock_cnt_next_s = lock_cnt_r + FILT_W'(1);
    end else begin
      lock_cnt_next_s = lock_cnt_r;
    end
  end

  assign lock_loss_s = !lock_s && (lock_cnt_r >= FILT_LAST);

  // Next-state and phase counter; ordering of the if-chain sets event priority
  always_comb begin
    next_s     = state_r;
    cnt_next_s = '0;
    case (state_r)
      WAIT_STABLE: begin
        if (stable_s && lock_s) begin
          next_s = HOLD;
        end else begin
          next_s = WAIT_STABLE;
        end
      end
      HOLD, RELEASE_CORE, RUN: begin
        if (lock_loss_s) begin
          next_s = FAULT;
        end else if (!stable_s || bus.SEQ_RESTART_H) begin
          next_s = WAIT_STABLE;
        end else if (state_r == HOLD && cnt_r == HOLD_LAST) begin
          next_s = RELEASE_CORE;
        end else if (state_r == RELEASE_CORE && cnt_r == STAG_LAST) begin
          next_s = RUN;
        end else begin
          next_s = state_r;
          if (state_r != RUN) begin
            cnt_next_s = cnt_r + CNT_W'(1);
          end else begin
            cnt_next_s = '0;
          end
        end
      end
      FAULT:   next_s = WAIT_STABLE;
      default: next_s = WAIT_STABLE;
    endcase
  end

  // State, counters and outputs; outputs decode next state so they switch on the transition edge
  always_ff @(posedge CLK_80MHz or posedge RESET_H) begin
    if (RESET_H) begin
      state_r        <= WAIT_STABLE;
      cnt_r          <= '0;
      lock_cnt_r     <= '0;
      loss_cnt_r     <= '0;
      core_reset_r   <= 1'b1;
      fabric_reset_r <= 1'b1;
      relock_r       <= 1'b0;
    end else begin
      state_r        <= next_s;
      cnt_r          <= cnt_next_s;
      lock_cnt_r     <= lock_cnt_next_s;
      core_reset_r   <= !(next_s == RELEASE_CORE || next_s == RUN);
      fabric_reset_r <= (next_s != RUN);
      relock_r       <= (next_s == FAULT);
      if (next_s == FAULT) begin
        loss_cnt_r <= sat_inc(loss_cnt_r);
      end else begin
        loss_cnt_r <= loss_cnt_r;
      end
    end
  end

  assign bus.CORE_RESET_H     = core_reset_r;
  assign bus.FABRIC_RESET_H   = fabric_reset_r;
  assign bus.RELOCK_REQUEST_H = relock_r;
  assign bus.SEQ_STATE        = state_r;
  assign bus.LOCK_LOSS_COUNT  = loss_cnt_r;

endmodule

// File: tb/tb_clock_domain_reset_sequencer.sv
// Directed and randomized bench for the reset sequencer; expectations come from
// a timeline model: an input change after edge D is acted on at edge D+SYNC+1.
module tb_clock_domain_reset_sequencer;

  localparam int SYNC  = 2;
  localparam int HOLD  = 16;
  localparam int STAG  = 8;
  localparam int LF    = 4;
  localparam int QUAL  = SYNC + 1;

  localparam logic [2:0] S_WAIT  = 3'd0;
  localparam logic [2:0] S_HOLD  = 3'd1;
  localparam logic [2:0] S_REL   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  int   exp_loss;

  clock_domain_reset_sequencer_if bus ();

  clock_domain_reset_sequencer #(
    .SYNC_STAGES        (SYNC),
    .HOLD_CYCLES        (HOLD),
    .STAGGER_CYCLES     (STAG),
    .LOCK_FILTER_CYCLES (LF)
  ) dut (
    .CLK_80MHz (clk),
    .RESET_H   (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #6 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
    int n;
    n = 0;
    while (bus.SEQ_STATE !== target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.SEQ_STATE), 32'(target));
  endtask

  function automatic int loss_after(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // Lock low for len cycles starting in RUN; loss expected only if len >= LF
  task automatic glitch(input int len);
    int  pulses;
    int  fault_off;
    int  left_run;
    logic both_rst;
    logic exp_fault;
    pulses    = 0;
    fault_off = -1;
    left_run  = 0;
    both_rst  = 1'b0;
    exp_fault = (len >= LF);
    bus.MMCM_LOCKED_H = 1'b0;
    for (int i = 1; i <= len + SYNC + 8; i++) begin
      tick();
      if (i == len) bus.MMCM_LOCKED_H = 1'b1;
      if (bus.RELOCK_REQUEST_H === 1'b1) pulses++;
      if (bus.SEQ_STATE !== S_RUN) left_run = 1;
      if (bus.SEQ_STATE === S_FAULT && fault_off < 0) begin
        fault_off = i;
        both_rst  = bus.CORE_RESET_H & bus.FABRIC_RESET_H;
      end
    end
    if (exp_fault) begin
      exp_loss = loss_after(exp_loss);
      check("glitch_fault_edge", 32'(fault_off), 32'(SYNC + LF));
      check("glitch_fault_resets", 32'(both_rst), 32'd1);
    end else begin
      check("glitch_stayed_run", 32'(left_run), 32'd0);
    end
    check("glitch_relock_pulses", 32'(pulses), 32'(exp_fault));
    check("glitch_loss_count", 32'(bus.LOCK_LOSS_COUNT), 32'(exp_loss));
    wait_state("glitch_back_to_run", S_RUN, 100);
    repeat (SYNC + 2) tick();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    exp_loss  = 0;
    rst = 1'b1;
    bus.CLOCKS_STABLE_H = 1'b0;
    bus.MMCM_LOCKED_H   = 1'b0;
    bus.SEQ_RESTART_H   = 1'b0;
    #15;
    check("reset_core", 32'(bus.CORE_RESET_H), 32'd1);
    check("reset_fabric", 32'(bus.FABRIC_RESET_H), 32'd1);
    check("reset_relock", 32'(bus.RELOCK_REQUEST_H), 32'd0);
    check("reset_state", 32'(bus.SEQ_STATE), 32'(S_WAIT));
    check("reset_count", 32'(bus.LOCK_LOSS_COUNT), 32'd0);

    // Power-up: inputs rise together before edge 1
    tick();
    rst = 1'b0;
    bus.CLOCKS_STABLE_H = 1'b1;
    bus.MMCM_LOCKED_H   = 1'b1;
    for (int e = 1; e <= QUAL + HOLD + STAG + 3; e++) begin
      logic [2:0] exp_st;
      tick();
      if (e < QUAL)                    exp_st = S_WAIT;
      else if (e < QUAL + HOLD)        exp_st = S_HOLD;
      else if (e < QUAL + HOLD + STAG) exp_st = S_REL;
      else                             exp_st = S_RUN;
      check("powerup_core", 32'(bus.CORE_RESET_H), 32'(e < QUAL + HOLD));
      check("powerup_fabric", 32'(bus.FABRIC_RESET_H), 32'(e < QUAL + HOLD + STAG));
      check("powerup_state", 32'(bus.SEQ_STATE), 32'(exp_st));
    end

    // Lock glitches: directed 3 and 4 cycles, then random lengths
    glitch(LF - 1);
    glitch(LF);
    for (int k = 0; k < 6; k++) glitch(int'($urandom_range(1, 7)));

    // Restart alone in RUN
    bus.SEQ_RESTART_H = 1'b1;
    tick();
    bus.SEQ_RESTART_H = 1'b0;
    check("restart_state", 32'(bus.SEQ_STATE), 32'(S_WAIT));
    check("restart_resets", 32'({bus.CORE_RESET_H, bus.FABRIC_RESET_H}), 32'd3);
    check("restart_relock", 32'(bus.RELOCK_REQUEST_H), 32'd0);
    check("restart_count", 32'(bus.LOCK_LOSS_COUNT), 32'(exp_loss));
    wait_state("restart_back_to_run", S_RUN, 100);
    repeat (SYNC + 2) tick();

    // Lock loss and restart on the same edge: loss wins
    bus.MMCM_LOCKED_H = 1'b0;
    repeat (SYNC + LF - 1) tick();
    bus.SEQ_RESTART_H = 1'b1;
    tick();
    bus.SEQ_RESTART_H = 1'b0;
    bus.MMCM_LOCKED_H = 1'b1;
    exp_loss = loss_after(exp_loss);
    check("collide_state", 32'(bus.SEQ_STATE), 32'(S_FAULT));
    check("collide_relock", 32'(bus.RELOCK_REQUEST_H), 32'd1);
    check("collide_count", 32'(bus.LOCK_LOSS_COUNT), 32'(exp_loss));

    // Forced losses until the counter saturates
    for (int k = 0; k < 300; k++) begin
      wait_state("force_hold", S_HOLD, 100);
      bus.MMCM_LOCKED_H = 1'b0;
      wait_state("force_fault", S_FAULT, 50);
      bus.MMCM_LOCKED_H = 1'b1;
      exp_loss = loss_after(exp_loss);
    end
    check("saturated_count", 32'(bus.LOCK_LOSS_COUNT), 32'(exp_loss));
    check("saturated_is_255", 32'(exp_loss), 32'(bus.LOCK_LOSS_COUNT == 8'd255 ? 255 : -1));

    // Asynchronous reset in RELEASE_CORE
    wait_state("reach_release", S_REL, 100);
    #2;
    rst = 1'b1;
    #1;
    exp_loss = 0;
    check("async_core", 32'(bus.CORE_RESET_H), 32'd1);
    check("async_fabric", 32'(bus.FABRIC_RESET_H), 32'd1);
    check("async_state", 32'(bus.SEQ_STATE), 32'(S_WAIT));
    check("async_count", 32'(bus.LOCK_LOSS_COUNT), 32'(exp_loss));
    check("async_relock", 32'(bus.RELOCK_REQUEST_H), 32'd0);

    // Stable drop in HOLD, then a full hold restart
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 11; e++) tick();
    bus.CLOCKS_STABLE_H = 1'b0;
    for (int e = 12; e <= 11 + QUAL; e++) begin
      tick();
      check("drop_state", 32'(bus.SEQ_STATE), 32'(e < 11 + QUAL ? S_HOLD : S_WAIT));
      check("drop_core", 32'(bus.CORE_RESET_H), 32'd1);
      check("drop_relock", 32'(bus.RELOCK_REQUEST_H), 32'd0);
    end
    bus.CLOCKS_STABLE_H = 1'b1;
    for (int e = 11 + QUAL + 1; e <= 11 + 2 * QUAL + HOLD; e++) begin
      tick();
      check("rehold_core", 32'(bus.CORE_RESET_H), 32'(e < 11 + 2 * QUAL + HOLD));
    end
    check("rehold_state", 32'(bus.SEQ_STATE), 32'(S_REL));
    check("rehold_count", 32'(bus.LOCK_LOSS_COUNT), 32'(exp_loss));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/clock_domain_reset_sequencer.md
CLOCK_DOMAIN_RESET_SEQUENCER -- requirements
Module: clock_domain_reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for CLOCKS_STABLE_H and MMCM_LOCKED_H.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: cycles CORE_RESET_H is held after inputs are qualified.
REQ-003 SHALL have parameter STAGGER_CYCLES, default 8: cycles between CORE_RESET_H release and FABRIC_RESET_H release.
REQ-004 SHALL have parameter LOCK_FILTER_CYCLES, default 4: consecutive synced-low lock cycles that count as a lock loss.
REQ-005 SHALL have CLK_80MHz  in  1  the only clock; all logic is on its rising edge.
REQ-006 SHALL have RESET_H  in  1  asynchronous, active-high reset.
REQ-007 SHALL have CLOCKS_STABLE_H  in  1  stable indication from the clock generator; treated as asynchronous.
REQ-008 SHALL have MMCM_LOCKED_H  in  1  raw MMCM LOCKED; treated as asynchronous.
REQ-009 SHALL have SEQ_RESTART_H  in  1  synchronous request to re-run the sequence.
REQ-010 SHALL have CORE_RESET_H  out  1  registered reset for core logic, active-high.
REQ-011 SHALL have FABRIC_RESET_H  out  1  registered reset for switch fabric logic, active-high.
REQ-012 SHALL have RELOCK_REQUEST_H  out  1  one-cycle pulse asking the clock generator to reset the MMCM.
REQ-013 SHALL have SEQ_STATE  out  3  current state encoding.
REQ-014 SHALL have LOCK_LOSS_COUNT  out  8  saturating count of lock-loss events.

Function
REQ-015 SHALL pass each of CLOCKS_STABLE_H and MMCM_LOCKED_H through a SYNC_STAGES-deep flip-flop synchronizer before any use; all later references mean the synced values.
REQ-016 SHALL implement states WAIT_STABLE=0, HOLD=1, RELEASE_CORE=2, RUN=3, FAULT=4; codes 5-7 SHALL go to WAIT_STABLE.
REQ-017 WAIT_STABLE: both resets asserted; when stable=1 and lock=1, SHALL go to HOLD with the cycle counter cleared.
REQ-018 HOLD: the counter SHALL increment each cycle; when it equals HOLD_CYCLES-1, the state SHALL go to RELEASE_CORE, counter cleared, and CORE_RESET_H SHALL deassert on the same edge.
REQ-019 RELEASE_CORE: the counter SHALL increment; when it equals STAGGER_CYCLES-1, the state SHALL go to RUN and FABRIC_RESET_H SHALL deassert on the same edge.
REQ-020 RUN: both resets SHALL stay deasserted.
REQ-021 Lock filter: a counter SHALL count consecutive cycles with synced lock=0 and clear on lock=1; reaching LOCK_FILTER_CYCLES SHALL signal lock loss, and shorter glitches SHALL be ignored.
REQ-022 Lock loss in HOLD, RELEASE_CORE or RUN SHALL go to FAULT; on that edge both resets SHALL assert and LOCK_LOSS_COUNT SHALL increment, saturating at 255.
REQ-023 FAULT SHALL last exactly one cycle, drive RELOCK_REQUEST_H=1 for that cycle only, then go to WAIT_STABLE.
REQ-024 Stable=0 in HOLD, RELEASE_CORE or RUN SHALL go to WAIT_STABLE with both resets asserted on the same edge; no count and no relock pulse.
REQ-025 SEQ_RESTART_H=1 in HOLD, RELEASE_CORE or RUN SHALL go to WAIT_STABLE with both resets asserted on the same edge.
REQ-026 Priority for simultaneous events SHALL be: lock loss > stable=0 > SEQ_RESTART_H > counter terminal.
REQ-027 FABRIC_RESET_H SHALL never be deasserted while CORE_RESET_H is asserted.

Reset
REQ-028 RESET_H SHALL immediately force: state WAIT_STABLE, CORE_RESET_H=1, FABRIC_RESET_H=1, RELOCK_REQUEST_H=0, LOCK_LOSS_COUNT=0, counters 0, synchronizers 0.
REQ-029 Assertion of RESET_H in any state, mid-sequence included, SHALL yield the same values as REQ-028.

Structure
REQ-030 The state enum, its width and the default parameter constants SHALL live in a shared package, clk_domain_pkg.
REQ-031 Synchronization SHALL use one sub-module, bit_synchronizer (parameter STAGES), instantiated twice.

Verification
REQ-032 Stable and lock rise together before edge 1 -> CORE_RESET_H falls at edge 19, FABRIC_RESET_H at edge 27, SEQ_STATE=3 from edge 27.
REQ-033 In RUN, lock low for 3 cycles -> no state change, count stays 0; lock low for 4 cycles -> FAULT, both resets high, RELOCK_REQUEST_H high exactly 1 cycle, count=1.
REQ-034 Stable drops at HOLD count 10 -> WAIT_STABLE next edge, CORE_RESET_H stays 1, no relock pulse; stable returns -> full 16-cycle hold restarts.
REQ-035 Lock loss and SEQ_RESTART_H in the same RUN cycle -> FAULT taken, count increments; 300 forced losses -> count=255.
REQ-036 RESET_H pulsed in RELEASE_CORE -> both resets 1 and SEQ_STATE=0 asynchronously; LOCK_LOSS_COUNT=0.
